// File: rtl/edit_mem_port_reader_pkg.sv
// Shared types and default widths for the edit-memory port reader.
// Width macros normally come from the shared defines header; the guarded
// fallbacks below keep this slice self-contained. EM_RD_LATENCY is the read
// latency that the edit memory and every reader must agree on.
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 12
`endif
`ifndef DATA_PATH_NBITS
`define DATA_PATH_NBITS 32
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 4
`endif
`ifndef EM_RD_LATENCY
`define EM_RD_LATENCY 2
`endif

package edit_mem_port_reader_pkg;

  localparam int unsigned EM_BUF_PTR_NBITS = `EM_BUF_PTR_NBITS;
  localparam int unsigned DATA_PATH_NBITS  = `DATA_PATH_NBITS;
  localparam int unsigned PORT_ID_NBITS    = `PORT_ID_NBITS;
  localparam int unsigned EM_RD_LATENCY    = `EM_RD_LATENCY;

  // Request FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/edit_mem_rd_fifo.sv
// Synchronous return-data FIFO for the edit-memory port reader.
// Ports: clk/rst (sync, active-high), push/push_data write side,
// pop/head read side (head is show-ahead), count and empty status.
// DEPTH must be a power of two.
module edit_mem_rd_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/edit_mem_port_reader.sv
// Per-egress-port reader for the shared edit-memory read interface.
// Takes packet descriptors (desc_*), issues one data_req per buffer toward
// the arbiter (data_req*, data_req_gnt), collects edit_mem_ack/rdata that
// return RD_LATENCY cycles after grant, and streams the packet to the port
// (port_*). desc_err pulses for a zero-length descriptor. em_rd_err is a
// sticky missing-ack flag, present only when EM_RD_ACK_CHECK_EN is defined.
module edit_mem_port_reader
  import edit_mem_port_reader_pkg::*;
#(
  parameter int unsigned BPTR_NBITS = EM_BUF_PTR_NBITS,
  parameter int unsigned DATA_NBITS = DATA_PATH_NBITS,
  parameter int unsigned ID_NBITS   = PORT_ID_NBITS,
  parameter int unsigned PORT_ID    = 0,
  parameter int unsigned LEN_NBITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = EM_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [BPTR_NBITS-1:0] desc_buf_ptr,
  input  logic [LEN_NBITS-1:0]  desc_nbuf,
  output logic                  data_req,
  output logic [ID_NBITS-1:0]   data_req_dst_port_id,
  output logic                  data_req_sop,
  output logic                  data_req_eop,
  output logic [BPTR_NBITS-1:0] data_req_buf_ptr,
  input  logic                  data_req_gnt,
  input  logic                  edit_mem_ack,
  input  logic [DATA_NBITS-1:0] edit_mem_rdata,
  output logic                  port_valid,
  input  logic                  port_ready,
  output logic [DATA_NBITS-1:0] port_data,
  output logic                  port_sop,
  output logic                  port_eop,
  output logic                  desc_err,
  output logic                  em_rd_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned FW = DATA_NBITS + 2;

  rd_state_e                  state;
  rd_state_e                  state_next;
  logic [BPTR_NBITS-1:0]      ptr;
  logic [LEN_NBITS-1:0]       rem;
  logic                       first;
  logic                       accept;
  logic                       grant;
  logic                       credit;
  logic [SW-1:0]              credit_sum;
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_empty;
  logic [FW-1:0]              fifo_head;
  logic [RD_LATENCY-1:0][2:0] trk;   // per stage {valid, sop, eop}
  logic                       trk_v;
  logic                       trk_sop;
  logic                       trk_eop;

  assign accept = desc_valid && desc_ready;
  assign grant  = data_req && data_req_gnt;

  // Credit counts both in-flight reads and buffered words so the FIFO cannot overflow
  assign credit_sum = SW'(outstanding) + SW'(fifo_count);
  assign credit     = credit_sum < SW'(FIFO_DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && (desc_nbuf != '0)) state_next = ST_REQ;
      ST_REQ:  if (grant && data_req_eop)       state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request outputs; fields only move on grant so they hold while ungranted
  always_comb begin
    data_req             = 1'b0;
    data_req_dst_port_id = ID_NBITS'(PORT_ID);
    data_req_sop         = first;
    data_req_eop         = (rem == LEN_NBITS'(1));
    data_req_buf_ptr     = ptr;
    if (state == ST_REQ) data_req = credit;
  end

  // Descriptor handshake is a registered function of the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_ready <= 1'b0;
      desc_err   <= 1'b0;
    end else begin
      desc_ready <= (state_next == ST_IDLE);
      desc_err   <= accept && (desc_nbuf == '0);
    end
  end

  // Packet walk: pointer, remaining count, first-buffer flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      rem   <= '0;
      first <= 1'b0;
    end else if (accept && (desc_nbuf != '0)) begin
      ptr   <= desc_buf_ptr;
      rem   <= desc_nbuf;
      first <= 1'b1;
    end else if (grant) begin
      ptr   <= ptr + BPTR_NBITS'(1);
      rem   <= rem - LEN_NBITS'(1);
      first <= 1'b0;
    end
  end

  // In-flight tracker; its last stage lines up with our own ack on the shared bus
  always_ff @(posedge clk) begin
    if (rst) begin
      trk <= '0;
    end else begin
      trk[0] <= {grant, data_req_sop, data_req_eop};
      for (int i = 1; i < int'(RD_LATENCY); i++) trk[i] <= trk[i-1];
    end
  end

  assign {trk_v, trk_sop, trk_eop} = trk[RD_LATENCY-1];

  // Granted reads whose data has not yet landed in the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({grant, trk_v})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  edit_mem_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (trk_v),
    .push_data ({edit_mem_rdata, trk_sop, trk_eop}),
    .pop       (port_valid && port_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign port_valid = !fifo_empty;
  assign port_data  = fifo_head[FW-1:2];
  assign port_sop   = fifo_head[1];
  assign port_eop   = fifo_head[0];

`ifdef EM_RD_ACK_CHECK_EN
  // Expected ack missing: flag it but still push the word to keep framing
  always_ff @(posedge clk) begin
    if (rst)                         em_rd_err <= 1'b0;
    else if (trk_v && !edit_mem_ack) em_rd_err <= 1'b1;
  end
`else
  logic unused_ack;
  assign unused_ack = edit_mem_ack;
  assign em_rd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_edit_mem_port_reader.sv
// Directed bench for edit_mem_port_reader with a small edit-memory responder
// that returns 0xD0000000|ptr two cycles after each grant.
module tb_edit_mem_port_reader;

  localparam int unsigned BW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_valid;
  logic          desc_ready;
  logic [BW-1:0] desc_buf_ptr;
  logic [LW-1:0] desc_nbuf;
  logic          data_req;
  logic [IW-1:0] data_req_dst_port_id;
  logic          data_req_sop;
  logic          data_req_eop;
  logic [BW-1:0] data_req_buf_ptr;
  logic          data_req_gnt;
  logic          edit_mem_ack;
  logic [DW-1:0] edit_mem_rdata;
  logic          port_valid;
  logic          port_ready;
  logic [DW-1:0] port_data;
  logic          port_sop;
  logic          port_eop;
  logic          desc_err;
  logic          em_rd_err;

  logic          foreign_ack;
  logic          suppress;
  logic [1:0]    mv = 2'b00;
  logic [BW-1:0] mp [2];
  int            grant_cnt = 0;
  int            g0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  edit_mem_port_reader #(
    .BPTR_NBITS (BW),
    .DATA_NBITS (DW),
    .ID_NBITS   (IW),
    .PORT_ID    (5),
    .LEN_NBITS  (LW),
    .FIFO_DEPTH (4),
    .RD_LATENCY (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .desc_valid           (desc_valid),
    .desc_ready           (desc_ready),
    .desc_buf_ptr         (desc_buf_ptr),
    .desc_nbuf            (desc_nbuf),
    .data_req             (data_req),
    .data_req_dst_port_id (data_req_dst_port_id),
    .data_req_sop         (data_req_sop),
    .data_req_eop         (data_req_eop),
    .data_req_buf_ptr     (data_req_buf_ptr),
    .data_req_gnt         (data_req_gnt),
    .edit_mem_ack         (edit_mem_ack),
    .edit_mem_rdata       (edit_mem_rdata),
    .port_valid           (port_valid),
    .port_ready           (port_ready),
    .port_data            (port_data),
    .port_sop             (port_sop),
    .port_eop             (port_eop),
    .desc_err             (desc_err),
    .em_rd_err            (em_rd_err)
  );

  // Edit-memory responder: ack + data two cycles after a grant
  always @(posedge clk) begin
    mv[0] <= data_req & data_req_gnt;
    mp[0] <= data_req_buf_ptr;
    mv[1] <= mv[0];
    mp[1] <= mp[0];
    if (data_req & data_req_gnt) grant_cnt <= grant_cnt + 1;
  end

  assign edit_mem_ack   = (mv[1] & ~suppress) | foreign_ack;
  assign edit_mem_rdata = mv[1] ? (32'hD000_0000 | 32'(mp[1])) : 32'hBAD0_BAD0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [BW-1:0] p,
                         input logic s, input logic e);
    chk({tag, ".req"}, data_req, req);
    chk({tag, ".ptr"}, data_req_buf_ptr, p);
    chk({tag, ".sop"}, data_req_sop, s);
    chk({tag, ".eop"}, data_req_eop, e);
  endtask

  task automatic chk_word(input string tag, input logic [DW-1:0] d, input logic s, input logic e);
    chk({tag, ".valid"}, port_valid, 1'b1);
    chk({tag, ".data"}, port_data, d);
    chk({tag, ".sop"}, port_sop, s);
    chk({tag, ".eop"}, port_eop, e);
  endtask

  // Collect n words starting at buffer p0 (pointer wraps at 12 bits)
  task automatic drain(input string tag, input int n, input logic [BW-1:0] p0);
    int got = 0;
    logic [BW-1:0] p;
    for (int c = 0; c < 40 && got < n; c++) begin
      if (port_valid && port_ready) begin
        p = p0 + BW'(got);
        chk_word(tag, 32'hD000_0000 | 32'(p), got == 0, got == n - 1);
        got++;
      end
      tick();
    end
    chk({tag, ".count"}, got, n);
  endtask

  initial begin
    rst = 1'b1; desc_valid = 1'b0; desc_buf_ptr = '0; desc_nbuf = '0;
    data_req_gnt = 1'b0; port_ready = 1'b0; foreign_ack = 1'b0; suppress = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst.desc_ready", desc_ready, 1'b0);
    chk_req("rst", 1'b0, 12'h000, 1'b0, 1'b0);
    chk("rst.port_valid", port_valid, 1'b0);
    chk("rst.desc_err", desc_err, 1'b0);
    chk("rst.em_rd_err", em_rd_err, 1'b0);
    chk("rst.dst_id", data_req_dst_port_id, 4'd5);
    rst = 1'b0;
    tick();
    chk("idle.desc_ready", desc_ready, 1'b1);

    // 1: three-buffer packet, immediate grant, first word in cycle 4
    desc_valid = 1'b1; desc_buf_ptr = 12'h010; desc_nbuf = 8'd3;
    data_req_gnt = 1'b1; port_ready = 1'b1;
    tick();
    desc_valid = 1'b0;
    chk("t1.desc_ready", desc_ready, 1'b0);
    chk_req("t1.r0", 1'b1, 12'h010, 1'b1, 1'b0);
    tick();
    chk_req("t1.r1", 1'b1, 12'h011, 1'b0, 1'b0);
    tick();
    chk_req("t1.r2", 1'b1, 12'h012, 1'b0, 1'b1);
    chk("t1.early_valid", port_valid, 1'b0);
    tick();
    chk("t1.req_done", data_req, 1'b0);
    chk("t1.ready_back", desc_ready, 1'b1);
    chk_word("t1.w0", 32'hD000_0010, 1'b1, 1'b0);
    tick();
    chk_word("t1.w1", 32'hD000_0011, 1'b0, 1'b0);
    tick();
    chk_word("t1.w2", 32'hD000_0012, 1'b0, 1'b1);
    tick();
    chk("t1.empty", port_valid, 1'b0);

    // 2: pointer wrap from all ones
    desc_valid = 1'b1; desc_buf_ptr = 12'hFFF; desc_nbuf = 8'd2;
    tick();
    desc_valid = 1'b0;
    chk_req("t2.r0", 1'b1, 12'hFFF, 1'b1, 1'b0);
    tick();
    chk_req("t2.r1", 1'b1, 12'h000, 1'b0, 1'b1);
    tick();
    chk("t2.req_done", data_req, 1'b0);
    drain("t2", 2, 12'hFFF);
    chk("t2.empty", port_valid, 1'b0);

    // 3: port stalled, credit limits to FIFO depth, then full drain
    port_ready = 1'b0; desc_valid = 1'b1; desc_buf_ptr = 12'h020; desc_nbuf = 8'd8;
    g0 = grant_cnt;
    tick();
    desc_valid = 1'b0;
    repeat (10) tick();
    chk("t3.grants", grant_cnt - g0, 4);
    chk_req("t3.held", 1'b0, 12'h024, 1'b0, 1'b0);
    chk_word("t3.head", 32'hD000_0020, 1'b1, 1'b0);
    port_ready = 1'b1;
    drain("t3", 8, 12'h020);
    chk("t3.empty", port_valid, 1'b0);
    chk("t3.grants_all", grant_cnt - g0, 8);

    // 4: grant pattern 1,0,0,1 with foreign acks on the shared bus
    desc_valid = 1'b1; desc_buf_ptr = 12'h030; desc_nbuf = 8'd2; data_req_gnt = 1'b1;
    tick();
    desc_valid = 1'b0;
    chk_req("t4.r1", 1'b1, 12'h030, 1'b1, 1'b0);
    tick();
    data_req_gnt = 1'b0; foreign_ack = 1'b1;
    chk_req("t4.r2", 1'b1, 12'h031, 1'b0, 1'b1);
    tick();
    foreign_ack = 1'b0;
    chk_req("t4.r3", 1'b1, 12'h031, 1'b0, 1'b1);
    tick();
    data_req_gnt = 1'b1; foreign_ack = 1'b1;
    chk_req("t4.r4", 1'b1, 12'h031, 1'b0, 1'b1);
    chk_word("t4.w0", 32'hD000_0030, 1'b1, 1'b0);
    tick();
    chk("t4.r5.req", data_req, 1'b0);
    chk("t4.r5.valid", port_valid, 1'b0);
    tick();
    foreign_ack = 1'b0;
    chk("t4.r6.valid", port_valid, 1'b0);
    tick();
    chk_word("t4.w1", 32'hD000_0031, 1'b0, 1'b1);
    tick();
    chk("t4.r8.valid", port_valid, 1'b0);
    tick();
    chk("t4.r9.valid", port_valid, 1'b0);

    // 5: zero-length descriptor, then next descriptor back to back
    desc_valid = 1'b1; desc_buf_ptr = 12'h055; desc_nbuf = 8'd0;
    tick();
    chk("t5.err", desc_err, 1'b1);
    chk("t5.no_req", data_req, 1'b0);
    chk("t5.ready", desc_ready, 1'b1);
    desc_buf_ptr = 12'h040; desc_nbuf = 8'd1;
    tick();
    desc_valid = 1'b0;
    chk("t5.err_clr", desc_err, 1'b0);
    chk("t5.desc_ready", desc_ready, 1'b0);
    chk_req("t5.r0", 1'b1, 12'h040, 1'b1, 1'b1);
    tick();
    chk("t5.req_done", data_req, 1'b0);
    drain("t5", 1, 12'h040);

    // 6: reset after two grants of a four-buffer packet
    port_ready = 1'b0; desc_valid = 1'b1; desc_buf_ptr = 12'h060; desc_nbuf = 8'd4;
    tick();
    desc_valid = 1'b0;
    tick();
    tick();
    chk_req("t6.pre", 1'b1, 12'h062, 1'b0, 1'b0);
    rst = 1'b1; data_req_gnt = 1'b0;
    tick();
    rst = 1'b0;
    chk_req("t6.rst", 1'b0, 12'h000, 1'b0, 1'b0);
    chk("t6.rst.desc_ready", desc_ready, 1'b0);
    chk("t6.rst.port_valid", port_valid, 1'b0);
    chk("t6.rst.desc_err", desc_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6.late_ack", port_valid, 1'b0);
    end
    chk("t6.ready_back", desc_ready, 1'b1);

`ifdef EM_RD_ACK_CHECK_EN
    chk("t6a.clear", em_rd_err, 1'b0);
    port_ready = 1'b1; desc_valid = 1'b1; desc_buf_ptr = 12'h070; desc_nbuf = 8'd1;
    data_req_gnt = 1'b1; suppress = 1'b1;
    tick();
    desc_valid = 1'b0;
    drain("t6a", 1, 12'h070);
    suppress = 1'b0;
    repeat (3) tick();
    chk("t6a.sticky", em_rd_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6a.rst", em_rd_err, 1'b0);
`else
    chk("t6.em_rd_err", em_rd_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
